// File: rtl/iob_eth_mii_rx.sv
// rtl/iob_eth_mii_rx.sv - MII receive frame engine: preamble strip, nibble packing, FCS check
// Writes received bytes to an external buffer and holds length/status until the host acks.
module iob_eth_mii_rx #(
  parameter int MAX_FRAME_BYTES = 2048,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int ADDR_W          = 11
) (
  input  logic              RX_CLK,
  input  logic              reset,
  input  logic [3:0]        RX_DATA,
  input  logic              RX_DV,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              frame_ready,
  output logic [15:0]       frame_len,
  output logic              crc_ok,
  input  logic              rx_ack,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PRE, DATA, DROP} state_t;

  state_t          state, state_n;
  logic [ADDR_W:0] byte_cnt;
  logic            phase;
  logic [3:0]      low_nib;
  logic [31:0]     crc;
  logic            busy, at_max;
  logic [7:0]      byte_in;
  logic            start, wr, fin, drop;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign busy    = frame_ready & ~rx_ack;
  assign byte_in = {RX_DATA, low_nib};
  assign at_max  = (byte_cnt == (ADDR_W+1)'(MAX_FRAME_BYTES));

  always_comb begin
    state_n = state;
    start   = 1'b0;
    wr      = 1'b0;
    fin     = 1'b0;
    drop    = 1'b0;
    case (state)
      WAIT_IDLE: if (!RX_DV) state_n = IDLE;
      IDLE: begin
        if (RX_DV) begin
          if (busy) begin
            state_n = DROP;
            drop    = 1'b1;
          end else if (RX_DATA == 4'h5) begin
            state_n = PRE;
          end else if (RX_DATA == 4'hD) begin
            state_n = DATA;
            start   = 1'b1;
          end else begin
            state_n = DROP;
            drop    = 1'b1;
          end
        end
      end
      PRE: begin
        if (!RX_DV) begin
          state_n = IDLE;
        end else if (RX_DATA == 4'hD) begin
          state_n = DATA;
          start   = 1'b1;
        end else if (RX_DATA != 4'h5) begin
          state_n = DROP;
          drop    = 1'b1;
        end
      end
      DATA: begin
        if (!RX_DV) begin
          state_n = IDLE;
          fin     = 1'b1;
        end else if (phase) begin
          // A byte beyond the buffer size aborts the frame without touching the held one.
          if (at_max) begin
            state_n = DROP;
            drop    = 1'b1;
          end else begin
            wr = 1'b1;
          end
        end
      end
      DROP: if (!RX_DV) state_n = IDLE;
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge reset) begin
    if (reset) begin
      state       <= WAIT_IDLE;
      byte_cnt    <= '0;
      phase       <= 1'b0;
      low_nib     <= 4'h0;
      crc         <= 32'hFFFFFFFF;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= 8'h00;
      frame_ready <= 1'b0;
      frame_len   <= 16'h0;
      crc_ok      <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      state  <= state_n;
      buf_we <= wr;
      if (start) begin
        byte_cnt <= '0;
        phase    <= 1'b0;
        crc      <= 32'hFFFFFFFF;
      end
      if (state == DATA && RX_DV) begin
        if (!phase) low_nib <= RX_DATA;
        phase <= ~phase;
      end
      if (wr) begin
        buf_addr  <= byte_cnt[ADDR_W-1:0];
        buf_wdata <= byte_in;
        byte_cnt  <= byte_cnt + 1'b1;
        crc       <= crc_byte(crc, byte_in);
      end
      if (rx_ack && frame_ready) frame_ready <= 1'b0;
      if (fin) begin
        frame_ready <= 1'b1;
        frame_len   <= 16'(byte_cnt);
        // Residue of a correct FCS run through the reflected register without final XOR.
        crc_ok      <= (crc == 32'hDEBB20E3) && !phase &&
                       (byte_cnt >= (ADDR_W+1)'(MIN_FRAME_BYTES));
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_eth_mii_rx.sv
// tb/tb_iob_eth_mii_rx.sv - randomized bench for iob_eth_mii_rx against a frame-level model
module tb_iob_eth_mii_rx;

  logic        RX_CLK = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  RX_DATA = 4'h0;
  logic        RX_DV  = 1'b0;
  logic        rx_ack = 1'b0;

  logic        buf_we, frame_ready, crc_ok;
  logic [10:0] buf_addr;
  logic [7:0]  buf_wdata, drop_cnt;
  logic [15:0] frame_len;

  logic        s_buf_we, s_frame_ready, s_crc_ok;
  logic [6:0]  s_buf_addr;
  logic [7:0]  s_buf_wdata, s_drop_cnt;
  logic [15:0] s_frame_len;

  iob_eth_mii_rx dut (
    .RX_CLK(RX_CLK), .reset(reset), .RX_DATA(RX_DATA), .RX_DV(RX_DV),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .frame_ready(frame_ready), .frame_len(frame_len), .crc_ok(crc_ok),
    .rx_ack(rx_ack), .drop_cnt(drop_cnt)
  );

  iob_eth_mii_rx #(.MAX_FRAME_BYTES(128), .MIN_FRAME_BYTES(64), .ADDR_W(7)) dut_small (
    .RX_CLK(RX_CLK), .reset(reset), .RX_DATA(RX_DATA), .RX_DV(RX_DV),
    .buf_we(s_buf_we), .buf_addr(s_buf_addr), .buf_wdata(s_buf_wdata),
    .frame_ready(s_frame_ready), .frame_len(s_frame_len), .crc_ok(s_crc_ok),
    .rx_ack(rx_ack), .drop_cnt(s_drop_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [18:0] wr_q[$];
  int          s_wr_cnt = 0;
  int          bad_we   = 0;

  always @(negedge RX_CLK) begin
    if (buf_we) wr_q.push_back({buf_addr, buf_wdata});
    if (buf_we && frame_ready) bad_we++;
    if (s_buf_we) s_wr_cnt++;
  end

  // Model state for the main instance
  bit          m_ready = 0;
  logic [15:0] m_len   = 0;
  bit          m_ok    = 0;
  int          m_drop  = 0;

  function automatic logic [31:0] ref_fcs(input logic [7:0] b[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  function automatic bit fcs_good(input logic [7:0] f[$]);
    int n = f.size();
    if (n < 4) return 0;
    return {f[n-1], f[n-2], f[n-3], f[n-4]} == ref_fcs(f, n - 4);
  endfunction

  task automatic make_frame(input int len, input bit bcast, output logic [7:0] f[$]);
    logic [31:0] c;
    f = {};
    for (int i = 0; i < len - 4; i++) f.push_back((bcast && i < 6) ? 8'hFF : 8'($urandom));
    c = ref_fcs(f, len - 4);
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
  endtask

  task automatic send(input logic [7:0] f[$], input int pre_n, input bit extra);
    @(negedge RX_CLK);
    RX_DV = 1'b1;
    for (int i = 0; i < pre_n; i++) begin RX_DATA = 4'h5; @(negedge RX_CLK); end
    RX_DATA = 4'hD; @(negedge RX_CLK);
    foreach (f[i]) begin
      RX_DATA = f[i][3:0]; @(negedge RX_CLK);
      RX_DATA = f[i][7:4]; @(negedge RX_CLK);
    end
    if (extra) begin RX_DATA = 4'($urandom); @(negedge RX_CLK); end
    RX_DV = 1'b0;
    RX_DATA = 4'h0;
    repeat (3) @(negedge RX_CLK);
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] f[$], input int pre_n, input bit extra);
    int nexp;
    wr_q = {};
    send(f, pre_n, extra);
    if (m_ready) begin
      nexp = 0;
      if (m_drop < 255) m_drop++;
    end else begin
      nexp    = f.size();
      m_ready = 1;
      m_len   = 16'(f.size());
      m_ok    = (f.size() >= 64) && !extra && fcs_good(f);
    end
    check({tag, "_nwr"}, wr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], {11'(i), f[i]});
    check({tag, "_ready"}, frame_ready, m_ready);
    check({tag, "_len"}, frame_len, m_len);
    check({tag, "_ok"}, crc_ok, m_ok);
    check({tag, "_drop"}, drop_cnt, m_drop);
  endtask

  task automatic ack(input string tag);
    @(negedge RX_CLK); rx_ack = 1'b1;
    @(negedge RX_CLK); rx_ack = 1'b0;
    m_ready = 0;
    check({tag, "_ack_ready"}, frame_ready, 0);
    check({tag, "_ack_len"}, frame_len, m_len);
    check({tag, "_ack_ok"}, crc_ok, m_ok);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    int len;
    bit ex, bad;

    repeat (3) @(negedge RX_CLK);
    check("rst_we", buf_we, 0);
    check("rst_addr", buf_addr, 0);
    check("rst_wdata", buf_wdata, 0);
    check("rst_ready", frame_ready, 0);
    check("rst_len", frame_len, 0);
    check("rst_ok", crc_ok, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge RX_CLK);

    // Oversize on the 128-byte instance, normal frame on the main one
    make_frame(200, 0, f);
    s_wr_cnt = 0;
    rx_frame("big200", f, 7, 0);
    check("small_nwr", s_wr_cnt, 128);
    check("small_ready", s_frame_ready, 0);
    check("small_drop", s_drop_cnt, 1);
    ack("big200");

    make_frame(64, 1, f);
    rx_frame("good64", f, 7, 0);
    check("good64_first", wr_q.size() > 0 ? wr_q[0][7:0] : 8'h00, 8'hFF);
    ack("good64");

    g = f;
    g[20] = g[20] ^ 8'h01;
    rx_frame("flip", g, 7, 0);
    check("flip_ok0", crc_ok, 0);
    ack("flip");

    rx_frame("odd", f, 7, 1);
    ack("odd");

    make_frame(63, 0, f);
    rx_frame("len63", f, 3, 0);
    ack("len63");

    make_frame(64, 0, f);
    rx_frame("busyA", f, 7, 0);
    make_frame(70, 0, g);
    rx_frame("busyB", g, 7, 0);
    ack("busyB");
    rx_frame("busyC", g, 2, 0);
    ack("busyC");

    // Bad start nibble counts a drop; preamble abandoned without SFD does not
    @(negedge RX_CLK); RX_DV = 1'b1; RX_DATA = 4'h3;
    repeat (4) @(negedge RX_CLK);
    RX_DV = 1'b0; repeat (2) @(negedge RX_CLK);
    m_drop++;
    check("badnib_drop", drop_cnt, m_drop);
    RX_DV = 1'b1; RX_DATA = 4'h5;
    repeat (4) @(negedge RX_CLK);
    RX_DV = 1'b0; repeat (2) @(negedge RX_CLK);
    check("prefall_drop", drop_cnt, m_drop);
    check("prefall_ready", frame_ready, 0);

    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(60, 100);
      make_frame(len, 0, f);
      bad = ($urandom_range(0, 2) == 0);
      ex  = ($urandom_range(0, 3) == 0);
      if (bad) f[$urandom_range(0, len - 1)] ^= 8'(1 << $urandom_range(0, 7));
      rx_frame($sformatf("rnd%0d", it), f, $urandom_range(0, 7), ex);
      ack($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a frame, then relock only after RX_DV drops
    make_frame(64, 0, f);
    @(negedge RX_CLK); RX_DV = 1'b1;
    for (int i = 0; i < 7; i++) begin RX_DATA = 4'h5; @(negedge RX_CLK); end
    RX_DATA = 4'hD; @(negedge RX_CLK);
    for (int i = 0; i < 30; i++) begin
      RX_DATA = f[i][3:0]; @(negedge RX_CLK);
      RX_DATA = f[i][7:4]; @(negedge RX_CLK);
    end
    reset = 1'b1;
    #1;
    m_ready = 0; m_len = 0; m_ok = 0; m_drop = 0;
    check("mid_we", buf_we, 0);
    check("mid_addr", buf_addr, 0);
    check("mid_wdata", buf_wdata, 0);
    check("mid_ready", frame_ready, 0);
    check("mid_len", frame_len, 0);
    check("mid_drop", drop_cnt, 0);
    @(negedge RX_CLK);
    reset = 1'b0;
    wr_q = {};
    for (int i = 0; i < 12; i++) begin
      RX_DATA = (i % 3 == 0) ? 4'hD : 4'($urandom);
      @(negedge RX_CLK);
    end
    check("mid_nwr", wr_q.size(), 0);
    RX_DV = 1'b0;
    repeat (3) @(negedge RX_CLK);
    check("mid_ready2", frame_ready, 0);
    make_frame(64, 1, f);
    rx_frame("after_rst", f, 7, 0);
    check("after_rst_ok1", crc_ok, 1);
    ack("after_rst");

    check("we_while_ready", bad_we, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_eth_mii_rx.md
Name: iob_eth_mii_rx

Overview:
- MII receive-side frame engine. Samples RX_DATA/RX_DV on RX_CLK, strips preamble/SFD, packs nibbles into bytes (low nibble first) and writes them to an external byte buffer.
- Checks the FCS with a running CRC-32 and reports length plus status for the host to consume.
- Counterpart of the team's MII transmit/loopback generator. Sits between the PHY RX pins and the Ethernet core's RX buffer.

Parameters:
- MAX_FRAME_BYTES, 2048: largest accepted frame in bytes, FCS included. Must be a power of 2.
- MIN_FRAME_BYTES, 64: smallest frame with crc_ok eligible, FCS included.
- ADDR_W, 11: buffer address width. Equals log2(MAX_FRAME_BYTES).

Ports:
- RX_CLK  input  1  MII receive clock; all logic on rising edge.
- reset  input  1  Asynchronous, active-high reset.
- RX_DATA  input  4  MII receive nibble.
- RX_DV  input  1  MII data valid.
- buf_we  output  1  Buffer write strobe, one cycle per byte.
- buf_addr  output  ADDR_W  Byte address, 0 = first byte after SFD.
- buf_wdata  output  8  Byte to write.
- frame_ready  output  1  Level: a completed frame is held for the host.
- frame_len  output  16  Byte count of held frame, FCS included.
- crc_ok  output  1  Held frame passed FCS, alignment and min-length checks.
- rx_ack  input  1  Host pulse; releases the held frame.
- drop_cnt  output  8  Saturating count of discarded frames.

Behaviour:
- Reset is asynchronous, active-high; clock is RX_CLK.
- Reset values: buf_we=0, buf_addr=0, buf_wdata=0, frame_ready=0, frame_len=0, crc_ok=0, drop_cnt=0, state=WAIT_IDLE.
- busy = frame_ready & ~rx_ack. rx_ack has priority over a frame start in the same cycle.
- WAIT_IDLE: RX_DV=0 -> IDLE. This prevents locking onto a frame already in progress when reset deasserts.
- IDLE, when RX_DV=1:
  - busy -> DROP, drop_cnt+1.
  - RX_DATA=5 -> PRE.
  - RX_DATA=D -> DATA.
  - any other nibble -> DROP, drop_cnt+1.
- IDLE entry to DATA (direct or via PRE) clears byte_cnt and nibble phase and sets crc=FFFFFFFF.
- PRE:
  - RX_DV=0 -> IDLE; no count.
  - RX_DATA=5 -> stay in PRE.
  - RX_DATA=D -> DATA.
  - any other nibble -> DROP, drop_cnt+1.
- DATA, RX_DV=1:
  - Even phase: latch nibble as low half.
  - Odd phase: byte = {RX_DATA, low}. Next cycle: buf_we=1, buf_addr=byte_cnt, buf_wdata=byte (1-cycle registered latency). byte_cnt+1.
  - crc updated with the byte: reflected CRC-32, poly EDB88320, LSB first, no final XOR.
  - If the byte would be number MAX_FRAME_BYTES+1: no write -> DROP, drop_cnt+1, frame_ready untouched.
- DATA, RX_DV=0 -> IDLE, with on the same edge:
  - frame_ready=1.
  - frame_len=byte_cnt.
  - crc_ok=1 only if all hold: crc==DEBB20E3, nibble phase even, byte_cnt>=MIN_FRAME_BYTES.
  - An odd trailing nibble is discarded and not written.
- DROP: RX_DV=0 -> IDLE. No buffer writes while in DROP.
- rx_ack with frame_ready=1: frame_ready=0 next edge; frame_len and crc_ok hold their values. rx_ack with frame_ready=0 is ignored.
- drop_cnt saturates at 255. It is cleared only by reset.
- Zero-byte frame (SFD then RX_DV low): reported with frame_len=0, crc_ok=0.
- buf_we never asserts while frame_ready=1. The host buffer contents stay stable until ack.
- Reset mid-frame: outputs return to reset values immediately. The engine resumes only after RX_DV is seen low.

Test Plan:
- 7×5, D, then 64-byte frame (dst FF:FF:FF:FF:FF:FF, valid FCS) -> 64 buf_we pulses, addr 0..63, first wdata=FF; frame_ready=1, frame_len=64, crc_ok=1.
- Same frame with bit 0 of byte 20 flipped -> frame_len=64, crc_ok=0; drop_cnt unchanged.
- Good 64-byte frame plus one extra nibble before RX_DV falls -> frame_len=64, crc_ok=0 (alignment); 64 writes only.
- Second good frame while frame_ready=1 and no ack -> no buf_we, drop_cnt=1, first frame_len unchanged. Ack, then third frame -> accepted, frame_ready=1.
- MAX_FRAME_BYTES=128, ADDR_W=7, 200-byte frame -> exactly 128 writes, no frame_ready, drop_cnt=1.
- Reset asserted after 30 data bytes with RX_DV still high -> all outputs 0. Remaining nibbles ignored. The next full good frame is received with crc_ok=1.
